fetch_stage: RTL and testbench

Instruction fetch stage of the Dragon pipeline, directly upstream of the IF/ID register. It owns the PC, issues in-order requests to instruction memory over a request/grant/response handshake, and buffers returned instructions in a DEPTH-entry FIFO. It presents one instruction per cycle with its PC and PC+4 to the IF/ID register, which consumes them under the hazard unit's enable. Branch and jump redirects from EX flush the buffer and discard in-flight responses.

---
 rtl/fetch_stage_if.sv | 28 ++
 rtl/fetch_stage.sv | 130 +++++++++++++
 tb/tb_fetch_stage.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: instruction-memory request/grant/response handshake plus the IF/ID hand-off.
// master = fetch stage side, slave = memory / pipeline side.
interface fetch_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic            redirect_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic            id_ready;
  logic            if_valid;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_pc_plus4;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_plus4,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect_i, redirect_pc_i, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_plus4,
    output imem_gnt, imem_rvalid, imem_rdata, redirect_i, redirect_pc_i, id_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// Dragon instruction fetch: owns the PC, issues credit-limited in-order fetches, buffers responses.
// Optional macro DRAGON_FETCH_BYPASS_EN presents a response straight to IF/ID when the buffer is empty.
module fetch_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 2
) (
  input logic           clk,
  input logic           reset,
  fetch_stage_if.master bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] pc;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   drop_cnt;

  logic [XLEN-1:0] tag_mem [DEPTH];
  logic [PW-1:0]   tag_wr, tag_rd;

  logic [31:0]     fifo_instr [DEPTH];
  logic [XLEN-1:0] fifo_pc    [DEPTH];
  logic [XLEN-1:0] fifo_pc4   [DEPTH];
  logic [PW-1:0]   fifo_wr, fifo_rd;
  logic [CW-1:0]   fifo_count;

  logic            credit_ok, issue, rsp_valid, rsp_keep, rsp_drop;
  logic            fifo_nonempty, push, pop;
  logic [XLEN-1:0] redirect_target;
  logic            unused_redirect_lsb;

  assign redirect_target     = {bus.redirect_pc_i[XLEN-1:2], 2'b00};
  assign unused_redirect_lsb = ^bus.redirect_pc_i[1:0];

  // Dropped-but-owed requests still hold credit, so the buffer can never be overrun.
  assign credit_ok     = ({1'b0, inflight} + {1'b0, fifo_count}) < DEPTH_C;
  assign bus.imem_req  = !reset && !bus.redirect_i && credit_ok;
  assign bus.imem_addr = pc;
  assign issue         = bus.imem_req && bus.imem_gnt;

  assign rsp_valid     = bus.imem_rvalid && (inflight != '0);
  assign rsp_drop      = rsp_valid && (drop_cnt != '0);
  assign rsp_keep      = rsp_valid && (drop_cnt == '0);
  assign fifo_nonempty = fifo_count != '0;
  assign pop           = fifo_nonempty && bus.id_ready && !bus.redirect_i;

`ifdef DRAGON_FETCH_BYPASS_EN
  logic bypass;
  assign bypass          = !fifo_nonempty && rsp_keep && !bus.redirect_i;
  assign bus.if_valid    = (fifo_nonempty || bypass) && !bus.redirect_i;
  assign bus.if_instr    = bypass ? bus.imem_rdata : fifo_instr[fifo_rd];
  assign bus.if_pc       = bypass ? tag_mem[tag_rd] : fifo_pc[fifo_rd];
  assign bus.if_pc_plus4 = bypass ? (tag_mem[tag_rd] + XLEN'(4)) : fifo_pc4[fifo_rd];
  assign push            = rsp_keep && !bus.redirect_i && !(bypass && bus.id_ready);
`else
  assign bus.if_valid    = fifo_nonempty;
  assign bus.if_instr    = fifo_instr[fifo_rd];
  assign bus.if_pc       = fifo_pc[fifo_rd];
  assign bus.if_pc_plus4 = fifo_pc4[fifo_rd];
  assign push            = rsp_keep && !bus.redirect_i;
`endif

  // A redirect converts every response still owed into a drop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      inflight <= inflight + CW'(issue) - CW'(rsp_valid);
      if (bus.redirect_i) begin
        pc       <= redirect_target;
        drop_cnt <= inflight - CW'(rsp_valid);
      end else begin
        if (issue) pc <= pc + XLEN'(4);
        drop_cnt <= drop_cnt - CW'(rsp_drop);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_wr <= '0;
      tag_rd <= '0;
      for (int i = 0; i < int'(DEPTH); i++) tag_mem[i] <= '0;
    end else if (bus.redirect_i) begin
      tag_wr <= '0;
      tag_rd <= '0;
    end else begin
      if (issue) begin
        tag_mem[tag_wr] <= pc;
        tag_wr          <= tag_wr + PW'(1);
      end
      if (rsp_keep) tag_rd <= tag_rd + PW'(1);
    end
  end

  // Storage is reset too so the head reads as zero while empty after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_wr    <= '0;
      fifo_rd    <= '0;
      fifo_count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_instr[i] <= '0;
        fifo_pc[i]    <= '0;
        fifo_pc4[i]   <= '0;
      end
    end else if (bus.redirect_i) begin
      fifo_wr    <= '0;
      fifo_rd    <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        fifo_instr[fifo_wr] <= bus.imem_rdata;
        fifo_pc[fifo_wr]    <= tag_mem[tag_rd];
        fifo_pc4[fifo_wr]   <= tag_mem[tag_rd] + XLEN'(4);
        fifo_wr             <= fifo_wr + PW'(1);
      end
      if (pop) fifo_rd <= fifo_rd + PW'(1);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  p_no_orphan_rsp: assert property (@(posedge clk) disable iff (reset)
    !(bus.imem_rvalid && (inflight == '0)));

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: in-order memory model, expected PCs queued at grant, checked at pop.
module tb_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] KEY      = 32'hA5A5_A5A5;
`ifdef DRAGON_FETCH_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic clk;
  logic reset = 1'b1;

  fetch_stage_if #(.XLEN(32)) bus ();

  fetch_stage #(.XLEN(32), .RESET_PC(RESET_PC), .DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          total = 0;
  int          bad = 0;
  int          grant_cnt = 0;
  logic [31:0] model_pc;
  logic [31:0] mem_q [$];
  logic [31:0] exp_q [$];
  logic        want_first = 1'b0;
  logic [31:0] first_pc = '0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One cycle: drive inputs at the falling edge, play memory, score pops and grants.
  task automatic applyStimulus(input logic redir, input logic [31:0] rpc, input logic rdy,
                               input logic gnt, input logic hold);
    logic [31:0] a;
    logic [31:0] p;
    @(negedge clk);
    bus.redirect_i    = redir;
    bus.redirect_pc_i = rpc;
    bus.id_ready      = rdy;
    bus.imem_gnt      = gnt;
    if (!hold && mem_q.size() > 0) begin
      a = mem_q.pop_front();
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = a ^ KEY;
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
    end
    #1;
    if (redir) begin
      checkOutput("redir_req", 32'(bus.imem_req), 32'd0);
      exp_q.delete();
      model_pc = {rpc[31:2], 2'b00};
    end else if (bus.if_valid && rdy) begin
      if (exp_q.size() == 0) begin
        checkOutput("spurious_valid", 32'(bus.if_valid), 32'd0);
      end else begin
        p = exp_q.pop_front();
        if (want_first) begin
          first_pc   = bus.if_pc;
          want_first = 1'b0;
        end
        checkOutput("if_pc", bus.if_pc, p);
        checkOutput("if_instr", bus.if_instr, p ^ KEY);
        checkOutput("if_pc_plus4", bus.if_pc_plus4, p + 32'd4);
      end
    end
    if (bus.imem_req && gnt) begin
      checkOutput("imem_addr", bus.imem_addr, model_pc);
      mem_q.push_back(bus.imem_addr);
      exp_q.push_back(model_pc);
      model_pc = model_pc + 32'd4;
      grant_cnt++;
    end
  endtask

  task automatic doReset(input logic mid);
    reset             = 1'b1;
    bus.imem_gnt      = 1'b0;
    bus.imem_rvalid   = 1'b0;
    bus.imem_rdata    = '0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = '0;
    bus.id_ready      = 1'b0;
    mem_q.delete();
    exp_q.delete();
    model_pc = RESET_PC;
    if (mid) begin
      #1;
      checkOutput("rst_async_valid", 32'(bus.if_valid), 32'd0);
      checkOutput("rst_async_req", 32'(bus.imem_req), 32'd0);
      checkOutput("rst_async_addr", bus.imem_addr, RESET_PC);
    end
    @(posedge clk);
    #1;
    checkOutput("rst_valid", 32'(bus.if_valid), 32'd0);
    checkOutput("rst_req", 32'(bus.imem_req), 32'd0);
    @(negedge clk);
    checkOutput("rst_instr", bus.if_instr, 32'd0);
    checkOutput("rst_pc", bus.if_pc, 32'd0);
    checkOutput("rst_pc4", bus.if_pc_plus4, 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("first_req", 32'(bus.imem_req), 32'd1);
    checkOutput("first_addr", bus.imem_addr, RESET_PC);
  endtask

  task automatic drain();
    repeat (6) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("drained", 32'(exp_q.size()), 32'd0);
    checkOutput("drain_valid", 32'(bus.if_valid), 32'd0);
  endtask

  initial begin
    doReset(1'b0);

    // Streaming from reset, then a reset in the middle of traffic.
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);
    doReset(1'b1);

    // Backpressure: only DEPTH requests may be granted while IF/ID stalls.
    grant_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
      if (i >= 2) begin
        checkOutput("bp_valid", 32'(bus.if_valid), 32'd1);
        checkOutput("bp_pc", bus.if_pc, 32'h0);
      end
    end
    checkOutput("bp_grants", 32'(grant_cnt), 32'd2);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);
    drain();

    // Redirect with two responses still owed.
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'h0000_0103, 1'b1, 1'b1, 1'b1);
    want_first = 1'b1;
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);
    checkOutput("redir_valid", 32'(bus.if_valid), 32'd0);
    checkOutput("redir_addr", bus.imem_addr, 32'h0000_0100);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);
    drain();
    checkOutput("redir_first_pc", first_pc, 32'h0000_0100);

    // Redirect coinciding with a returning response and a ready valid head.
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h0000_0200, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);
    checkOutput("redir2_valid", 32'(bus.if_valid), 32'd0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);
    drain();

    // Grant stall: address holds until the grant arrives.
    applyStimulus(1'b1, 32'h0000_0010, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
      checkOutput("stall_addr", bus.imem_addr, 32'h0000_0010);
      checkOutput("stall_req", 32'(bus.imem_req), 32'd1);
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("stall_next_addr", bus.imem_addr, 32'h0000_0014);
    drain();

    // Response-to-output latency from an empty buffer.
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("lat_same_cycle", 32'(bus.if_valid), 32'(BYP));
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("lat_next_cycle", 32'(bus.if_valid), 32'(!BYP));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
